// File: rtl/timer_pkg.sv
// Shared register map, channel config bit positions and types for the timer alarm scheduler.
package timer_pkg;

  localparam logic [31:0] CTRL_OFF   = 32'h00;
  localparam logic [31:0] STATUS_OFF = 32'h04;
  localparam logic [31:0] CH_BASE    = 32'h10;
  localparam logic [31:0] CH_STRIDE  = 32'h10;

  localparam logic [3:0] CMP_OFF    = 4'h0;
  localparam logic [3:0] PERIOD_OFF = 4'h4;
  localparam logic [3:0] CFG_OFF    = 4'h8;
  localparam logic [3:0] OVR_OFF    = 4'hC;

  localparam int CFG_ARM = 0;
  localparam int CFG_PER = 1;
  localparam int CFG_IRQ = 2;

  localparam logic [7:0] OVR_MAX = 8'd255;

  typedef enum logic {CH_IDLE, CH_ARMED} ch_state_e;

  // Per-channel write strobes decoded by the top.
  typedef struct packed {
    logic cmp;
    logic period;
    logic cfg;
    logic clr;
  } ch_wr_t;

endpackage

// File: rtl/timer_alarm_ch.sv
// One compare channel: CMP/PERIOD/CFG/OVR registers, wrap-safe hit compare and reload adder.
module timer_alarm_ch
  import timer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic [31:0] i_timer_value,
  input  ch_wr_t      i_wr,
  input  logic [31:0] i_wdata,
  input  logic        i_pending,
  output logic        o_hit,
  output logic [31:0] o_cmp,
  output logic [31:0] o_period,
  output logic [2:0]  o_cfg,
  output logic [7:0]  o_ovr
);

  logic [31:0] cmp_q, period_q, diff;
  logic [2:0]  cfg_q;
  logic [7:0]  ovr_q;
  logic        reload;
  ch_state_e   st;

  assign st     = cfg_q[CFG_ARM] ? CH_ARMED : CH_IDLE;
  assign diff   = i_timer_value - cmp_q;
  // Sign of the modular difference: anything up to 2^31 behind the timer counts as reached.
  assign o_hit  = (st == CH_ARMED) && i_en && !diff[31];
  assign reload = cfg_q[CFG_PER] && (period_q != 32'd0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cmp_q    <= '0;
      period_q <= '0;
      cfg_q    <= '0;
      ovr_q    <= '0;
    end else begin
      // Software writes to CMP or CFG suppress the hit's own update of this channel.
      if (i_wr.cmp)
        cmp_q <= i_wdata;
      else if (o_hit && reload && !i_wr.cfg)
        cmp_q <= cmp_q + period_q;

      if (i_wr.period)
        period_q <= i_wdata;

      if (i_wr.cfg)
        cfg_q <= i_wdata[2:0];
      else if (o_hit && !reload && !i_wr.cmp)
        cfg_q[CFG_ARM] <= 1'b0;

      if (i_wr.clr)
        ovr_q <= '0;
      else if (o_hit && i_pending && (ovr_q != OVR_MAX))
        ovr_q <= ovr_q + 8'd1;
    end
  end

  assign o_cmp    = cmp_q;
  assign o_period = period_q;
  assign o_cfg    = cfg_q;
  assign o_ovr    = ovr_q;

endmodule

// File: rtl/timer_alarm_ctrl.sv
// Alarm scheduler top: bus decode, CTRL/STATUS, read mux, irq register and NUM_CH channels.
module timer_alarm_ctrl
  import timer_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic [31:0] i_timer_value,
  output logic        o_timer_en,
  output logic        o_irq
);

  localparam logic [31:0] CH_END = CH_BASE + CH_STRIDE * NUM_CH;

  logic                          en_q, irq_q;
  logic [NUM_CH-1:0]             pending_q, hit, irq_en, ch_sel, clr_mask;
  logic [NUM_CH-1:0][31:0]       cmp, period;
  logic [NUM_CH-1:0][2:0]        cfg;
  logic [NUM_CH-1:0][7:0]        ovr;
  logic [31:0]                   off, chan_off;
  logic                          is_ctrl, is_stat, in_ch;
  ch_wr_t [NUM_CH-1:0]           ch_wr;

  assign off      = i_addr - BASE_ADDR;
  assign chan_off = off - CH_BASE;
  assign is_ctrl  = (off == CTRL_OFF);
  assign is_stat  = (off == STATUS_OFF);
  assign in_ch    = (off >= CH_BASE) && (off < CH_END) && (off[1:0] == 2'b00);
  assign clr_mask = (i_we && is_stat) ? i_wdata[NUM_CH-1:0] : '0;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      assign ch_sel[c]        = in_ch && (chan_off[31:4] == 28'(c));
      assign ch_wr[c].cmp     = i_we && ch_sel[c] && (chan_off[3:0] == CMP_OFF);
      assign ch_wr[c].period  = i_we && ch_sel[c] && (chan_off[3:0] == PERIOD_OFF);
      assign ch_wr[c].cfg     = i_we && ch_sel[c] && (chan_off[3:0] == CFG_OFF);
      assign ch_wr[c].clr     = clr_mask[c];
      assign irq_en[c]        = cfg[c][CFG_IRQ];

      timer_alarm_ch u_ch (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_en          (en_q),
        .i_timer_value (i_timer_value),
        .i_wr          (ch_wr[c]),
        .i_wdata       (i_wdata),
        .i_pending     (pending_q[c]),
        .o_hit         (hit[c]),
        .o_cmp         (cmp[c]),
        .o_period      (period[c]),
        .o_cfg         (cfg[c]),
        .o_ovr         (ovr[c])
      );
    end
  endgenerate

  // A hit on the same edge as its W1C keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      en_q      <= 1'b0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (i_we && is_ctrl)
        en_q <= i_wdata[0];
      pending_q <= (pending_q & ~clr_mask) | hit;
      irq_q     <= |(pending_q & irq_en);
    end
  end

  always_comb begin
    o_rdata = '0;
    if (is_ctrl)
      o_rdata = {31'd0, en_q};
    else if (is_stat)
      o_rdata[NUM_CH-1:0] = pending_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) begin
        case (chan_off[3:0])
          CMP_OFF:    o_rdata = cmp[i];
          PERIOD_OFF: o_rdata = period[i];
          CFG_OFF:    o_rdata = {29'd0, cfg[i]};
          OVR_OFF:    o_rdata = {24'd0, ovr[i]};
          default:    o_rdata = '0;
        endcase
      end
    end
  end

  assign o_timer_en = en_q;
  assign o_irq      = irq_q;

endmodule
